// File: rtl/vc_output_allocator_pkg.sv
// Shared defaults and requester-state encodings for the per-output-port VC allocator.
package vc_output_allocator_pkg;
  localparam int V_DEFAULT     = 4;
  localparam int N_REQ_DEFAULT = 4;

  localparam logic [1:0] REQ_IDLE   = 2'b00;
  localparam logic [1:0] REQ_WAIT   = 2'b01;
  localparam logic [1:0] REQ_ACTIVE = 2'b10;
endpackage

// File: rtl/vc_output_allocator_if.sv
// Request/release/availability inputs and grant/binding outputs of one output-port VC allocator.
interface vc_output_allocator_if
  import vc_output_allocator_pkg::*;
#(
  parameter int N_REQ = N_REQ_DEFAULT,
  parameter int V     = V_DEFAULT
);
  logic [N_REQ-1:0]   req_i;
  logic [N_REQ-1:0]   tail_sent_i;
  logic [V-1:0]       vc_avail_i;
  logic [N_REQ-1:0]   grant_o;
  logic [V-1:0]       sel_out_vc_o;
  logic [N_REQ*V-1:0] alloc_vc_o;
  logic [V-1:0]       vc_busy_o;

  modport master (
    output req_i, tail_sent_i, vc_avail_i,
    input  grant_o, sel_out_vc_o, alloc_vc_o, vc_busy_o
  );

  modport slave (
    input  req_i, tail_sent_i, vc_avail_i,
    output grant_o, sel_out_vc_o, alloc_vc_o, vc_busy_o
  );
endinterface

// File: rtl/vc_output_allocator_rr_arbiter.sv
// Pointer-based round-robin arbiter: combinational one-hot grant plus the pointer value to load
// when the caller accepts the grant. Shared with the switch allocator.
module vc_output_allocator_rr_arbiter #(
  parameter int N = 4
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] ptr,
  output logic [N-1:0]         gnt,
  output logic                 any,
  output logic [$clog2(N)-1:0] ptr_nxt
);
  localparam int PW = $clog2(N);

  logic [N-1:0] hi_mask_s;
  logic [N-1:0] hi_req_s;
  logic [N-1:0] pick_src_s;
  logic         found_s;

  // Requests at or above the pointer take priority; otherwise wrap to the lowest request.
  always_comb begin
    hi_mask_s = '0;
    for (int i = 0; i < N; i++) begin
      hi_mask_s[i] = (i >= int'(ptr));
    end
    hi_req_s   = req & hi_mask_s;
    pick_src_s = (|hi_req_s) ? hi_req_s : req;
    gnt        = '0;
    found_s    = 1'b0;
    ptr_nxt    = '0;
    for (int i = 0; i < N; i++) begin
      gnt[i]  = pick_src_s[i] & ~found_s;
      found_s = found_s | pick_src_s[i];
      ptr_nxt = ptr_nxt | (gnt[i] ? PW'((i + 1) % N) : '0);
    end
    any = |req;
  end
endmodule

// File: rtl/vc_output_allocator.sv
// Per-output-port VC allocator: round-robin over requesters, binds the lowest free available
// downstream VC, and holds that binding until the requester's tail flit leaves.
module vc_output_allocator
  import vc_output_allocator_pkg::*;
#(
  parameter int N_REQ = N_REQ_DEFAULT,
  parameter int V     = V_DEFAULT
) (
  input logic                  clk,
  input logic                  rstn,
  vc_output_allocator_if.slave bus
);
  localparam int PW = $clog2(N_REQ);
  localparam int AW = N_REQ * V;

  logic [N_REQ-1:0][1:0] state_r;
  logic [N_REQ-1:0][1:0] state_nxt_s;
  logic [AW-1:0]         alloc_r;
  logic [AW-1:0]         alloc_nxt_s;
  logic [V-1:0]          busy_r;
  logic [V-1:0]          busy_nxt_s;
  logic [N_REQ-1:0]      grant_r;
  logic [V-1:0]          sel_r;
  logic [PW-1:0]         ptr_r;

  logic [N_REQ-1:0]      cand_s;
  logic [N_REQ-1:0]      arb_gnt_s;
  logic                  arb_any_s;
  logic [PW-1:0]         ptr_nxt_s;
  logic [V-1:0]          elig_s;
  logic [V-1:0]          vc_pick_s;
  logic                  vc_found_s;
  logic                  fire_s;

  // Candidates are requesters raising req_i that do not already own a VC.
  always_comb begin
    cand_s = '0;
    for (int r = 0; r < N_REQ; r++) begin
      cand_s[r] = bus.req_i[r] & (state_r[r] != REQ_ACTIVE);
    end
  end

  vc_output_allocator_rr_arbiter #(.N(N_REQ)) u_arb (
    .req     (cand_s),
    .ptr     (ptr_r),
    .gnt     (arb_gnt_s),
    .any     (arb_any_s),
    .ptr_nxt (ptr_nxt_s)
  );

  // Lowest-index eligible VC; a VC released this cycle stays busy until the next one.
  always_comb begin
    elig_s     = ~busy_r & bus.vc_avail_i;
    vc_pick_s  = '0;
    vc_found_s = 1'b0;
    for (int v = 0; v < V; v++) begin
      vc_pick_s[v] = elig_s[v] & ~vc_found_s;
      vc_found_s   = vc_found_s | elig_s[v];
    end
    fire_s = arb_any_s & vc_found_s;
  end

  // Requester FSMs and VC bindings; a requester is never both released and granted in one cycle.
  always_comb begin
    state_nxt_s = state_r;
    alloc_nxt_s = alloc_r;
    busy_nxt_s  = busy_r;
    for (int r = 0; r < N_REQ; r++) begin
      case (state_r[r])
        REQ_IDLE:   state_nxt_s[r] = bus.req_i[r] ? REQ_WAIT : REQ_IDLE;
        REQ_WAIT:   state_nxt_s[r] = bus.req_i[r] ? REQ_WAIT : REQ_IDLE;
        REQ_ACTIVE: state_nxt_s[r] = bus.tail_sent_i[r] ? REQ_IDLE : REQ_ACTIVE;
        default:    state_nxt_s[r] = REQ_IDLE;
      endcase
      if ((state_r[r] == REQ_ACTIVE) && bus.tail_sent_i[r]) begin
        alloc_nxt_s[r*V +: V] = '0;
        busy_nxt_s            = busy_nxt_s & ~alloc_r[r*V +: V];
      end else if (fire_s && arb_gnt_s[r]) begin
        state_nxt_s[r]        = REQ_ACTIVE;
        alloc_nxt_s[r*V +: V] = vc_pick_s;
        busy_nxt_s            = busy_nxt_s | vc_pick_s;
      end else begin
        alloc_nxt_s[r*V +: V] = alloc_r[r*V +: V];
      end
    end
  end

  // Registered state, bindings, one-cycle grant pulse and round-robin pointer.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_r <= {N_REQ{REQ_IDLE}};
      alloc_r <= '0;
      busy_r  <= '0;
      grant_r <= '0;
      sel_r   <= '0;
      ptr_r   <= '0;
    end else begin
      state_r <= state_nxt_s;
      alloc_r <= alloc_nxt_s;
      busy_r  <= busy_nxt_s;
      grant_r <= fire_s ? arb_gnt_s : '0;
      sel_r   <= fire_s ? vc_pick_s : '0;
      ptr_r   <= fire_s ? ptr_nxt_s : ptr_r;
    end
  end

  assign bus.grant_o      = grant_r;
  assign bus.sel_out_vc_o = sel_r;
  assign bus.alloc_vc_o   = alloc_r;
  assign bus.vc_busy_o    = busy_r;
endmodule

// File: tb/tb_vc_output_allocator.sv
// Scoreboard bench for vc_output_allocator: directed scenarios plus random traffic against a
// VC-ownership reference model.
module tb_vc_output_allocator;
  localparam int NR = 4;
  localparam int NV = 4;
  localparam int AW = NR * NV;

  typedef struct {
    logic [NR-1:0] grant;
    logic [NV-1:0] sel;
    logic [AW-1:0] alloc;
    logic [NV-1:0] busy;
  } exp_t;

  logic          clk = 1'b0;
  logic          rstn;
  logic [NR-1:0] req;
  logic [NR-1:0] tail;
  logic [NV-1:0] avail;

  int   n_checks = 0;
  int   n_pass   = 0;
  exp_t exp_q[$];
  int   vc_of[NR];
  int   rr;

  vc_output_allocator_if #(.N_REQ(NR), .V(NV)) bus ();

  assign bus.req_i       = req;
  assign bus.tail_sent_i = tail;
  assign bus.vc_avail_i  = avail;

  vc_output_allocator #(.N_REQ(NR), .V(NV)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  task automatic model_reset();
    for (int r = 0; r < NR; r++) vc_of[r] = -1;
    rr = 0;
    exp_q.delete();
  endtask

  // One clock edge of the reference: vc_of[r] is the VC owned by requester r, -1 if none.
  task automatic model_step();
    exp_t          e;
    logic [NV-1:0] busy_pre;
    logic [NV-1:0] elig;
    int            pick;
    int            win;
    int            best_d;
    int            d;
    busy_pre = '0;
    for (int r = 0; r < NR; r++)
      if (vc_of[r] >= 0) busy_pre = busy_pre | (NV'(1) << vc_of[r]);
    elig = ~busy_pre & avail;
    pick = -1;
    for (int v = NV - 1; v >= 0; v--) if (elig[v]) pick = v;
    win    = -1;
    best_d = NR;
    for (int r = 0; r < NR; r++) begin
      d = (r - rr + NR) % NR;
      if (req[r] && (vc_of[r] < 0) && (d < best_d)) begin
        best_d = d;
        win    = r;
      end
    end
    for (int r = 0; r < NR; r++) if ((vc_of[r] >= 0) && tail[r]) vc_of[r] = -1;
    e.grant = '0;
    e.sel   = '0;
    if ((win >= 0) && (pick >= 0)) begin
      for (int r = 0; r < NR; r++) if (r == win) vc_of[r] = pick;
      rr      = (win + 1) % NR;
      e.grant = NR'(1) << win;
      e.sel   = NV'(1) << pick;
    end
    e.alloc = '0;
    e.busy  = '0;
    for (int r = 0; r < NR; r++) begin
      if (vc_of[r] >= 0) begin
        e.alloc = e.alloc | (AW'(1) << (r * NV + vc_of[r]));
        e.busy  = e.busy | (NV'(1) << vc_of[r]);
      end
    end
    exp_q.push_back(e);
  endtask

  function automatic logic inv_ok(logic [AW-1:0] a, logic [NV-1:0] b);
    logic [NV-1:0] acc;
    logic [NV-1:0] s;
    int            owners;
    logic          ok;
    acc    = '0;
    owners = 0;
    ok     = 1'b1;
    for (int r = 0; r < NR; r++) begin
      s = a[r*NV +: NV];
      if ($countones(s) > 1) ok = 1'b0;
      if ((s & acc) != '0) ok = 1'b0;
      acc = acc | s;
      if (s != '0) owners++;
    end
    if (acc != b) ok = 1'b0;
    if ($countones(b) != owners) ok = 1'b0;
    return ok;
  endfunction

  initial begin : model
    model_reset();
    forever begin
      @(posedge clk or negedge rstn);
      if (!rstn) model_reset();
      else model_step();
    end
  end

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (rstn) begin
        chk("sb_depth", 64'(exp_q.size()), 64'd1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          chk("sb_grant", 64'(bus.grant_o), 64'(e.grant));
          chk("sb_sel", 64'(bus.sel_out_vc_o), 64'(e.sel));
          chk("sb_alloc", 64'(bus.alloc_vc_o), 64'(e.alloc));
          chk("sb_busy", 64'(bus.vc_busy_o), 64'(e.busy));
        end
        chk("invariant", 64'(inv_ok(bus.alloc_vc_o, bus.vc_busy_o)), 64'd1);
      end
    end
  end

  task automatic apply_reset();
    @(negedge clk);
    rstn = 1'b0;
    req  = '0;
    tail = '0;
    @(negedge clk);
    rstn = 1'b1;
  endtask

  task automatic chk_outputs_zero(string tag);
    chk({tag, "_grant"}, 64'(bus.grant_o), 64'd0);
    chk({tag, "_sel"}, 64'(bus.sel_out_vc_o), 64'd0);
    chk({tag, "_alloc"}, 64'(bus.alloc_vc_o), 64'd0);
    chk({tag, "_busy"}, 64'(bus.vc_busy_o), 64'd0);
  endtask

  initial begin : stim
    rstn  = 1'b0;
    req   = '0;
    tail  = '0;
    avail = '0;
    repeat (2) @(negedge clk);
    chk_outputs_zero("reset");
    rstn = 1'b1;

    // Single requester, all VCs free.
    req   = 4'b0001;
    avail = 4'b1111;
    @(negedge clk);
    chk("t1_grant", 64'(bus.grant_o), 64'h1);
    chk("t1_sel", 64'(bus.sel_out_vc_o), 64'h1);
    chk("t1_busy", 64'(bus.vc_busy_o), 64'h1);
    req = '0;

    // All four request: one grant per cycle in round-robin order, VCs in index order.
    apply_reset();
    req   = 4'b1111;
    avail = 4'b1111;
    for (int i = 0; i < NR; i++) begin
      @(negedge clk);
      chk("t2_grant", 64'(bus.grant_o), 64'd1 << i);
      chk("t2_sel", 64'(bus.sel_out_vc_o), 64'd1 << i);
    end
    @(negedge clk);
    chk("t2_idle", 64'(bus.grant_o), 64'd0);

    // Everything busy or unavailable; a tail frees VC2 and r0 gets it two cycles later.
    req   = '0;
    tail  = 4'b0001;
    avail = 4'b1110;
    @(negedge clk);
    tail = '0;
    req  = 4'b0001;
    @(negedge clk);
    chk("t3_blocked", 64'(bus.grant_o), 64'd0);
    tail = 4'b0100;
    @(negedge clk);
    chk("t3_release_cycle", 64'(bus.grant_o), 64'd0);
    tail = '0;
    @(negedge clk);
    chk("t3_grant", 64'(bus.grant_o), 64'h1);
    chk("t3_sel", 64'(bus.sel_out_vc_o), 64'h4);
    req = '0;

    // No VC available until VC1 appears.
    apply_reset();
    req   = 4'b0001;
    avail = 4'b0000;
    repeat (2) begin
      @(negedge clk);
      chk("t4_noavail", 64'(bus.grant_o), 64'd0);
    end
    avail = 4'b0010;
    @(negedge clk);
    chk("t4_grant", 64'(bus.grant_o), 64'h1);
    chk("t4_sel", 64'(bus.sel_out_vc_o), 64'h2);

    // Tail and new request from r1 in the same cycle: release first, regrant next cycle.
    apply_reset();
    req   = 4'b0010;
    avail = 4'b1111;
    @(negedge clk);
    chk("t5_grant0", 64'(bus.grant_o), 64'h2);
    chk("t5_sel0", 64'(bus.sel_out_vc_o), 64'h1);
    req = '0;
    @(negedge clk);
    tail = 4'b0010;
    req  = 4'b0010;
    @(negedge clk);
    chk("t5_rel_alloc", 64'(bus.alloc_vc_o), 64'd0);
    chk("t5_rel_busy", 64'(bus.vc_busy_o), 64'd0);
    chk("t5_rel_grant", 64'(bus.grant_o), 64'd0);
    tail = '0;
    @(negedge clk);
    chk("t5_regrant", 64'(bus.grant_o), 64'h2);
    chk("t5_resel", 64'(bus.sel_out_vc_o), 64'h1);

    // Asynchronous reset mid-traffic, then round-robin restarts at r0.
    req = 4'b1111;
    @(negedge clk);
    chk("t6_pre_grant", 64'(bus.grant_o), 64'h4);
    #2;
    rstn = 1'b0;
    #1;
    chk_outputs_zero("t6_async");
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    chk("t6_restart_grant", 64'(bus.grant_o), 64'h1);
    chk("t6_restart_sel", 64'(bus.sel_out_vc_o), 64'h1);
    req = '0;

    // Random traffic: sticky requests with occasional drops, sparse tails, flickering availability.
    apply_reset();
    for (int c = 0; c < 1500; c++) begin
      @(negedge clk);
      for (int r = 0; r < NR; r++) begin
        if (req[r]) req[r] = ($urandom_range(0, 9) != 0);
        else req[r] = ($urandom_range(0, 2) == 0);
        tail[r] = ($urandom_range(0, 5) == 0);
      end
      for (int v = 0; v < NV; v++) avail[v] = ($urandom_range(0, 4) != 0);
    end
    @(negedge clk);
    req  = '0;
    tail = '0;
    repeat (3) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
